mempool_rob: RTL and testbench
==============================

# mempool_rob

Parametrised response reorder buffer for the MemPool TCDM interconnect. It allocates a reorder ID (`reorder_id_t`-style tag) per outgoing core request and stores out-of-order responses from the banks by ID. It releases response data to the core strictly in allocation order. It sits between a core's TCDM request port and the interconnect, and generalises the fixed `ReorderIdWidth` tagging to a configurable depth and data width, with error reporting.

## Interface
- `DataWidth`, default 32: response payload width in bits.
- `NumIds`, default 8: number of outstanding slots. Must be a power of two, ≥2.
- `IdWidth`, default `$clog2(NumIds)`: derived parameter; do not override.
- `clk_i`, in, 1: clock. Single clock domain.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `req_valid_i`, in, 1: core wants to issue a request and needs an ID.
- `req_ready_o`, out, 1: a slot is free. Equal to `!full_o`.
- `req_id_o`, out, IdWidth: ID granted when `req_valid_i && req_ready_o`.
- `resp_valid_i`, in, 1: bank response arriving. No back-pressure; always consumed.
- `resp_id_i`, in, IdWidth: ID of the arriving response.
- `resp_data_i`, in, DataWidth: payload of the arriving response.
- `rsp_valid_o`, out, 1: in-order response available at head.
- `rsp_data_o`, out, DataWidth: head payload.
- `rsp_ready_i`, in, 1: core accepts the head response.
- `outstanding_o`, out, IdWidth+1: allocated but not yet released slot count.
- `full_o`, out, 1: `outstanding_o == NumIds`.
- `empty_o`, out, 1: `outstanding_o == 0`.
- `err_o`, out, 1: one-cycle pulse on a spurious response.

## Operation
- State:
  - `alloc_ptr` and `head_ptr`, each IdWidth+1 bits with a wrap bit.
  - `alloc_q[NumIds]`: slot is outstanding.
  - `done_q[NumIds]`: data has arrived.
  - `mem_q[NumIds][DataWidth]`: payload storage.
- Allocate:
  - `req_id_o = alloc_ptr[IdWidth-1:0]`.
  - On handshake, set `alloc_q[id]` and increment `alloc_ptr` modulo 2·NumIds.
- Response:
  - If `resp_valid_i && alloc_q[resp_id_i] && !done_q[resp_id_i]`, write `mem_q[resp_id_i]` and set `done_q`.
  - Otherwise drop the data, leave state unchanged, and assert `err_o` the next cycle.
- Release:
  - `rsp_valid_o = done_q[head]`, `rsp_data_o = mem_q[head]`, where head is `head_ptr[IdWidth-1:0]`.
  - On `rsp_valid_o && rsp_ready_i`: clear `alloc_q[head]` and `done_q[head]`, then increment `head_ptr`.
- Pointer status:
  - full: pointer indices are equal and wrap bits differ.
  - empty: pointers are fully equal.
  - `outstanding_o = alloc_ptr - head_ptr` (IdWidth+1-bit subtraction).
- Simultaneous events in one cycle: allocate, response and release may all occur. Each acts on its own slot.
  - A response to the head slot in the cycle it is released is impossible, because `done_q` is already set; such a response is spurious and flagged.
- No same-cycle slot reuse: `req_ready_o` is computed from the registered `full_o` only. A release in a full cycle does not enable allocation until the next cycle.
- `rsp_valid_o` must stay asserted with stable data until accepted.

## Timing
- Reset (synchronous, `rst_i` high at a clock edge):
  - Pointers and all `alloc_q`/`done_q` bits cleared. `mem_q` is not reset.
  - Outputs: `req_ready_o=1`, `req_id_o=0`, `rsp_valid_o=0`, `outstanding_o=0`, `full_o=0`, `empty_o=1`, `err_o=0`. `rsp_data_o` is don't-care while `rsp_valid_o=0`.
- Reset mid-operation: all outstanding IDs are forgotten. Responses arriving after reset for pre-reset IDs are flagged by `err_o`.
- Response-to-release latency: a response to the head slot in cycle N gives `rsp_valid_o=1` in cycle N+1. There is no combinational bypass.
- Throughput: one allocation and one release per cycle in steady state.
- `err_o` is registered: spurious response in cycle N, pulse in cycle N+1, for exactly one cycle per spurious event.
- No combinational path from `resp_*_i` or `rsp_ready_i` to any output.
- `req_ready_o` depends only on state.

## Test plan
- In-order smoke test (NumIds=8): allocate IDs 0,1,2; respond in order with 0xA0,0xA1,0xA2; hold `rsp_ready_i=1` → outputs 0xA0,0xA1,0xA2 on consecutive cycles, then `empty_o=1`.
- Reorder: allocate 0..3; respond in order 3,1,0,2 with data 0x30,0x10,0x00,0x20 → `rsp_valid_o` stays low until ID 0 arrives; output sequence is 0x00,0x10,0x20,0x30.
- Full and wrap:
  - Allocate 8 → `full_o=1`, `req_ready_o=0`, `outstanding_o=8`.
  - Release one → `req_ready_o` rises the following cycle.
  - Next grant is ID 0 with the wrap bit toggled.
  - Run 3 full wraps with random response order and check data integrity.
- Back-pressure: head data valid with `rsp_ready_i=0` for 5 cycles → `rsp_valid_o` and `rsp_data_o` stay stable; later responses are stored; all drain in order once ready.
- Spurious responses:
  - Response to an unallocated ID 5 → `err_o` pulses one cycle and state is unchanged.
  - Duplicate response to a done ID → original data is kept and `err_o` pulses.
- Reset mid-flight: 4 outstanding with 2 done, assert `rst_i` for one cycle → `empty_o=1`, `rsp_valid_o=0`. A later response to old ID 2 gives `err_o=1`, and the next grant is ID 0.

Source files
------------

// File: rtl/mempool_rob_if.sv
// Core-side request/response bundle for the reorder buffer.
// Carries the ID request handshake, bank responses, in-order release and status.
// slave: the reorder buffer; master: the core/interconnect side driving it.
interface mempool_rob_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IdWidth   = 3
);
  // request / ID grant
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [IdWidth-1:0]   req_id_o;
  // bank response (always consumed)
  logic                 resp_valid_i;
  logic [IdWidth-1:0]   resp_id_i;
  logic [DataWidth-1:0] resp_data_i;
  // in-order release to the core
  logic                 rsp_valid_o;
  logic [DataWidth-1:0] rsp_data_o;
  logic                 rsp_ready_i;
  // status
  logic [IdWidth:0]     outstanding_o;
  logic                 full_o;
  logic                 empty_o;
  logic                 err_o;

  modport slave (
    input  req_valid_i, resp_valid_i, resp_id_i, resp_data_i, rsp_ready_i,
    output req_ready_o, req_id_o, rsp_valid_o, rsp_data_o,
           outstanding_o, full_o, empty_o, err_o
  );

  modport master (
    output req_valid_i, resp_valid_i, resp_id_i, resp_data_i, rsp_ready_i,
    input  req_ready_o, req_id_o, rsp_valid_o, rsp_data_o,
           outstanding_o, full_o, empty_o, err_o
  );
endinterface

// File: rtl/mempool_rob.sv
// Response reorder buffer: tags each request with an ID, stores out-of-order
// bank responses by ID and releases them in allocation order.
// Latency: response to head slot in cycle N is visible on rsp_valid_o in N+1.
// Backpressure: req_ready_o drops when all NumIds slots are outstanding;
// rsp_valid_o/rsp_data_o hold until rsp_ready_i; responses are never stalled.
// Ports: clk_i, rst_i (sync, active-high), rob (mempool_rob_if.slave).
module mempool_rob #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned NumIds    = 8,
  parameter int unsigned IdWidth   = $clog2(NumIds)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mempool_rob_if.slave rob
);

  typedef logic [IdWidth:0]   ptr_t;
  typedef logic [IdWidth-1:0] id_t;

  localparam ptr_t PtrOne = ptr_t'(1);

  // pointers carry an extra wrap bit to tell full from empty
  ptr_t                 alloc_ptr;
  ptr_t                 head_ptr;
  logic [NumIds-1:0]    alloc_q;
  logic [NumIds-1:0]    done_q;
  logic [DataWidth-1:0] mem_q [NumIds];
  logic                 err_q;

  id_t  alloc_idx;
  id_t  head_idx;
  logic full;
  logic empty;
  logic alloc_fire;
  logic rel_fire;
  logic resp_ok;

  assign alloc_idx = alloc_ptr[IdWidth-1:0];
  assign head_idx  = head_ptr[IdWidth-1:0];

  assign full  = (alloc_idx == head_idx) && (alloc_ptr[IdWidth] != head_ptr[IdWidth]);
  assign empty = (alloc_ptr == head_ptr);

  // full is purely state-derived, so a slot freed this cycle is only
  // reusable from the next cycle on
  assign alloc_fire = rob.req_valid_i && !full;
  assign rel_fire   = done_q[head_idx] && rob.rsp_ready_i;

  // a response is accepted only for an allocated, not-yet-answered slot;
  // this also rejects a response to the head in its release cycle
  assign resp_ok = rob.resp_valid_i && alloc_q[rob.resp_id_i] && !done_q[rob.resp_id_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alloc_ptr <= '0;
      head_ptr  <= '0;
      alloc_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      // allocate, release and response always touch distinct slots
      if (alloc_fire) begin
        alloc_q[alloc_idx] <= 1'b1;
        alloc_ptr          <= alloc_ptr + PtrOne;
      end
      if (rel_fire) begin
        alloc_q[head_idx] <= 1'b0;
        done_q[head_idx]  <= 1'b0;
        head_ptr          <= head_ptr + PtrOne;
      end
      if (resp_ok) begin
        done_q[rob.resp_id_i] <= 1'b1;
      end
      err_q <= rob.resp_valid_i && !resp_ok;
    end
  end

  // payload storage is not reset; validity is tracked by done_q
  always_ff @(posedge clk_i) begin
    if (resp_ok) begin
      mem_q[rob.resp_id_i] <= rob.resp_data_i;
    end
  end

  assign rob.req_ready_o   = !full;
  assign rob.req_id_o      = alloc_idx;
  assign rob.rsp_valid_o   = done_q[head_idx];
  assign rob.rsp_data_o    = mem_q[head_idx];
  assign rob.outstanding_o = alloc_ptr - head_ptr;
  assign rob.full_o        = full;
  assign rob.empty_o       = empty;
  assign rob.err_o         = err_q;

endmodule

// File: tb/tb_mempool_rob.sv
// Scoreboard bench for mempool_rob (NumIds=8, DataWidth=32).
// Driver issues directed vectors and queues expected in-order payloads;
// a negedge monitor pops/compares releases, checks hold stability and err pulses.
module tb_mempool_rob;

  localparam int DW  = 32;
  localparam int NID = 8;
  localparam int IW  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mempool_rob_if #(.DataWidth(DW), .IdWidth(IW)) bus ();

  mempool_rob #(.DataWidth(DW), .NumIds(NID)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rob   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] sb[$];     // expected release order
  bit            err_cyc[int];
  int            next_id = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc();
    bus.req_valid_i = 1'b1;
    check("grant_ready", 32'(bus.req_ready_o), 32'd1);
    check("grant_id", 32'(bus.req_id_o), 32'(next_id));
    step();
    bus.req_valid_i = 1'b0;
    next_id = (next_id + 1) % NID;
  endtask

  task automatic respond(input int id, input logic [DW-1:0] d, input bit spurious);
    bus.resp_valid_i = 1'b1;
    bus.resp_id_i    = IW'(id);
    bus.resp_data_i  = d;
    if (spurious) err_cyc[cyc + 1] = 1'b1;
    step();
    bus.resp_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    next_id = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    bus.rsp_ready_i = 1'b1;
    while ((sb.size() != 0 || !bus.empty_o) && n < 64) begin
      step();
      n++;
    end
    if (n >= 64) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
    end else begin
      check({name, "_empty"}, 32'(bus.empty_o), 32'd1);
    end
  endtask

  // ---------------- monitor ----------------
  logic          hold_vld = 1'b0;
  logic [DW-1:0] hold_dat = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_vld = 1'b0;
    end else begin
      if (hold_vld) begin
        check("hold_valid", 32'(bus.rsp_valid_o), 32'd1);
        check("hold_data", bus.rsp_data_o, hold_dat);
      end
      if (bus.rsp_valid_o && bus.rsp_ready_i) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_rsp: got %h expected none", bus.rsp_data_o);
        end else begin
          check("rsp_data", bus.rsp_data_o, sb.pop_front());
        end
      end
      hold_vld = bus.rsp_valid_o && !bus.rsp_ready_i;
      hold_dat = bus.rsp_data_o;
      if (err_cyc.exists(cyc) || bus.err_o)
        check("err_pulse", 32'(bus.err_o), 32'(err_cyc.exists(cyc)));
    end
  end

  // ---------------- driver ----------------
  int            order[NID];
  logic [DW-1:0] wdat[NID];
  int            wid[NID];

  initial begin
    bus.req_valid_i  = 1'b0;
    bus.resp_valid_i = 1'b0;
    bus.resp_id_i    = '0;
    bus.resp_data_i  = '0;
    bus.rsp_ready_i  = 1'b1;
    rst = 1'b1;
    step();
    step();
    // reset state
    check("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
    check("rst_req_id", 32'(bus.req_id_o), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_outstanding", 32'(bus.outstanding_o), 32'd0);
    check("rst_full", 32'(bus.full_o), 32'd0);
    check("rst_empty", 32'(bus.empty_o), 32'd1);
    check("rst_err", 32'(bus.err_o), 32'd0);
    rst = 1'b0;

    // in-order smoke
    alloc(); alloc(); alloc();
    check("smoke_outstanding", 32'(bus.outstanding_o), 32'd3);
    sb.push_back(32'hA0); sb.push_back(32'hA1); sb.push_back(32'hA2);
    respond(0, 32'hA0, 0);
    respond(1, 32'hA1, 0);
    respond(2, 32'hA2, 0);
    drain("smoke");

    // reorder: 3,1,0,2
    do_reset();
    alloc(); alloc(); alloc(); alloc();
    sb.push_back(32'h00); sb.push_back(32'h10); sb.push_back(32'h20); sb.push_back(32'h30);
    respond(3, 32'h30, 0);
    respond(1, 32'h10, 0);
    check("reorder_wait", 32'(bus.rsp_valid_o), 32'd0);
    respond(0, 32'h00, 0);
    respond(2, 32'h20, 0);
    drain("reorder");

    // full and wrap
    do_reset();
    for (int i = 0; i < NID; i++) alloc();
    check("full_flag", 32'(bus.full_o), 32'd1);
    check("full_ready", 32'(bus.req_ready_o), 32'd0);
    check("full_outstanding", 32'(bus.outstanding_o), 32'd8);
    sb.push_back(32'hB0);
    respond(0, 32'hB0, 0);
    check("rel_cycle_valid", 32'(bus.rsp_valid_o), 32'd1);
    check("rel_cycle_ready", 32'(bus.req_ready_o), 32'd0);
    step();
    check("after_rel_ready", 32'(bus.req_ready_o), 32'd1);
    check("after_rel_outstanding", 32'(bus.outstanding_o), 32'd7);
    alloc();  // ID 0 again, wrap bit toggled
    check("wrap_full", 32'(bus.full_o), 32'd1);
    check("wrap_outstanding", 32'(bus.outstanding_o), 32'd8);
    for (int i = 1; i < NID; i++) sb.push_back(32'hB0 + 32'(i));
    sb.push_back(32'hB8);
    for (int i = 1; i < NID; i++) respond(i, 32'hB0 + 32'(i), 0);
    respond(0, 32'hB8, 0);
    drain("wrap0");

    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < NID; k++) begin
        wid[k]  = next_id;
        wdat[k] = 32'hC000_0000 | (32'(w) << 8) | 32'(k);
        sb.push_back(wdat[k]);
        order[k] = k;
        alloc();
      end
      for (int k = NID - 1; k > 0; k--) begin
        int j;
        int t;
        j = int'($urandom_range(k, 0));
        t = order[k]; order[k] = order[j]; order[j] = t;
      end
      for (int k = 0; k < NID; k++) respond(wid[order[k]], wdat[order[k]], 0);
      drain("wrap_rand");
    end

    // back-pressure
    do_reset();
    alloc(); alloc(); alloc();
    bus.rsp_ready_i = 1'b0;
    sb.push_back(32'hD0); sb.push_back(32'hD1); sb.push_back(32'hD2);
    respond(0, 32'hD0, 0);
    respond(2, 32'hD2, 0);
    respond(1, 32'hD1, 0);
    step(); step();
    check("bp_valid", 32'(bus.rsp_valid_o), 32'd1);
    check("bp_data", bus.rsp_data_o, 32'hD0);
    check("bp_outstanding", 32'(bus.outstanding_o), 32'd3);
    drain("bp");

    // spurious responses
    do_reset();
    alloc(); alloc();
    bus.rsp_ready_i = 1'b0;
    respond(5, 32'hDEAD, 1);
    step();
    check("spur_outstanding", 32'(bus.outstanding_o), 32'd2);
    check("spur_valid", 32'(bus.rsp_valid_o), 32'd0);
    respond(0, 32'hE0, 0);
    respond(0, 32'hBAD0, 1);
    step();
    check("dup_keep", bus.rsp_data_o, 32'hE0);
    sb.push_back(32'hE0); sb.push_back(32'hE1);
    respond(1, 32'hE1, 0);
    drain("spur");

    // reset mid-flight
    do_reset();
    for (int i = 0; i < 4; i++) alloc();
    bus.rsp_ready_i = 1'b0;
    respond(1, 32'hF1, 0);
    respond(3, 32'hF3, 0);
    check("mid_outstanding", 32'(bus.outstanding_o), 32'd4);
    do_reset();
    check("mid_empty", 32'(bus.empty_o), 32'd1);
    check("mid_valid", 32'(bus.rsp_valid_o), 32'd0);
    respond(2, 32'hF2, 1);
    alloc();
    sb.push_back(32'hF0);
    respond(0, 32'hF0, 0);
    drain("mid");
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
